// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencing controller.
package shift_seq_pkg;

  // Datapath width used when the instantiating level does not override it.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Bits needed to hold a shift count from 0 up to and including width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_reg_core.sv
// Plain WIDTH-bit left-shift register. Load has priority over shift; the
// fill bit enters at the LSB. No sequencing lives here.
module shift_reg_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic             fill,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Register: load a new value or shift left by one, filling the LSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], fill};
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// One-job-at-a-time controller for the left-shift datapath.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready is high only in IDLE; res_valid is high only in
// DONE and res_data is held stable until res_ready is seen. Neither
// req_valid nor res_ready reaches any output combinationally.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [CNT_W-1:0] req_amt,
  input  logic             fill_bit,
  input  logic             abort,
  output logic             busy,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] MAX_AMT = CNT_W'(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] data_q;
  logic             fill_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] amt_clamped;
  logic [WIDTH-1:0] q;
  logic             load;
  logic             shift_en;

  // Counts beyond WIDTH would only shift fill bits over fill bits.
  assign amt_clamped = (req_amt > MAX_AMT) ? MAX_AMT : req_amt;

  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and state-decoded outputs; abort wins over everything busy.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    busy       = 1'b0;
    ser_valid  = 1'b0;
    ser_out    = 1'b0;
    res_valid  = 1'b0;
    res_data   = '0;
    load       = 1'b0;
    shift_en   = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        busy = 1'b1;
        load = 1'b1;
        if (abort) begin
          state_next = S_IDLE;
        end else if (cnt == '0) begin
          state_next = S_DONE;
        end else begin
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy      = 1'b1;
        shift_en  = 1'b1;
        ser_valid = 1'b1;
        ser_out   = q[WIDTH-1];
        if (abort) begin
          state_next = S_IDLE;
        end else if (cnt == CNT_W'(1)) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        res_data  = q;
        if (abort || res_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Job registers: capture on accept, count shifts down, clear on abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      fill_q <= 1'b0;
      cnt    <= '0;
    end else if (state == S_IDLE && req_valid) begin
      data_q <= req_data;
      fill_q <= fill_bit;
      cnt    <= amt_clamped;
    end else if (state != S_IDLE && abort) begin
      cnt <= '0;
    end else if (state == S_SHIFT) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  shift_reg_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .shift_en (shift_en),
    .fill     (fill_q),
    .d        (data_q),
    .q        (q)
  );

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencing controller for the 8-bit left-shift register datapath. It accepts a byte and a shift count over a valid/ready request port. It loads the register, issues exactly the requested number of left shifts (filling with a programmable bit) and streams the MSB out serially. It then holds the result on a valid/ready result port until the consumer takes it. It sits between a command source (CPU register block or test sequencer) and the shift datapath, replacing free-running load/reset toggling with a controlled, one-job-at-a-time handshake.

## Interface
Parameters:
- WIDTH, 8, datapath width in bits (≥2)
- CNT_W, $clog2(WIDTH+1), width of shift-count field

Ports:
- clk  in  1  rising-edge clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_data  in  WIDTH  byte to load
- req_amt  in  CNT_W  number of left shifts to perform
- fill_bit  in  1  value shifted into LSB; sampled at accept
- abort  in  1  cancel current job
- busy  out  1  high in LOAD/SHIFT/DONE
- ser_out  out  1  MSB shifted out this cycle (valid when ser_valid)
- ser_valid  out  1  one pulse per shift performed
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  WIDTH  shifted value

## Operation
- States: IDLE, LOAD, SHIFT, DONE. Reset state IDLE.
- Reset values: res_valid=0, res_data=0, ser_out=0, ser_valid=0, busy=0. The internal register and count are also 0. req_ready=1 as soon as reset_n deasserts, because it is decoded from IDLE.
- IDLE: req_ready=1. When req_valid&&req_ready:
  - capture req_data, fill_bit and amt = min(req_amt, WIDTH);
  - move to LOAD.
- LOAD (1 cycle): write the captured byte into the shift register. Next state is SHIFT if amt>0, otherwise DONE.
- SHIFT: each cycle:
  - reg <= {reg[WIDTH-2:0], fill};
  - ser_out = reg[WIDTH-1] (pre-shift value), ser_valid=1;
  - cnt decrements.
  - The last shift (cnt==1) moves to DONE.
- DONE: res_valid=1 and res_data=reg, both held stable until res_valid&&res_ready. On that handshake, return to IDLE with res_valid=0.
- Clamping: req_amt>WIDTH behaves as WIDTH, giving a result of all fill_bit. Exactly WIDTH serial bits are emitted.
- abort (synchronous, sampled each edge) in LOAD/SHIFT/DONE:
  - next state IDLE, res_valid=0, ser_valid=0;
  - the partial result is discarded and no res handshake occurs.
  - Abort in IDLE is ignored and does not block a same-cycle accept.
- Abort and res_ready in the same DONE cycle: abort wins, but the net outcome is identical (IDLE, no further valid).
- req_valid while busy: ignored (req_ready=0). The requester must hold its request until accepted.
- Reset mid-job: immediate return to IDLE with all outputs at reset values. No partial result or ser_valid after reset_n rises.

## Timing
- Accept at edge 0 → LOAD during cycle 1 → first ser_valid in cycle 2.
- res_valid first asserts in cycle amt+2 (cycle 2 for amt=0).
- Throughput: one job per amt+3 cycles minimum (accept, load, amt shifts, one DONE cycle with res_ready=1).
- All outputs registered or decoded from state/registers only. There are no combinational paths from req_valid or res_ready to any output.
- ser_out/ser_valid are registered alongside the shift, so they are aligned with the shift cycle as seen by the consumer.

## Structure
- Package shift_seq_pkg:
  - state enum (IDLE/LOAD/SHIFT/DONE, 2-bit encoding);
  - default WIDTH constant;
  - CNT_W helper function.
- Sub-module shift_reg_core: WIDTH-bit left-shift register with load, shift_en, fill, reset_n and q. The controller drives load/shift_en; all sequencing lives in shift_seq_ctrl.
- Expected size: ~180–250 lines of RTL total.

## Test plan
- Reset then req 0xA5, amt=3, fill=0 → res_data=0x28 in cycle 5; ser_out bits 1,0,1; ser_valid exactly 3 cycles.
- amt=0, data 0x3C → res_valid in cycle 2, res_data=0x3C, no ser_valid pulses.
- amt=12 (clamped), fill=1, data 0x00 → res_data=0xFF; 8 ser_valid pulses, all ser_out=0.
- res_ready held low 10 cycles in DONE → res_valid/res_data stable, req_ready=0; new req_valid not accepted until handshake.
- abort in second SHIFT cycle of an amt=5 job → IDLE next cycle, no res_valid, req_ready=1; following job 0x01 amt=1 → 0x02.
- reset_n pulsed low mid-SHIFT → outputs zero asynchronously, IDLE on release, req_ready=1.
